// File: rtl/cu_phase_ctrl.sv
// rtl/cu_phase_ctrl.sv - compute-unit phase sequencer for inference and training passes
// Optional CU_PHASE_PERF_EN adds the perfCycles busy-cycle counter port.
module cu_phase_ctrl #(
  parameter int SysDimension = 16,
  parameter int NumLayers    = 3,
  parameter int cntWidth     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic [cntWidth-1:0] streamLength,
  input  logic                halt,
  output logic                enable,
  output logic [1:0]          sel1,
  output logic [1:0]          sel2,
  output logic                enact,
  output logic                enactd,
  output logic                enwu,
  output logic                weightWriteEnableA,
  output logic [3:0]          layerIdx,
  output logic                busy,
`ifdef CU_PHASE_PERF_EN
  output logic [31:0]         perfCycles,
`endif
  output logic                done
);

  typedef enum logic [2:0] {IDLE, INF, FW, BW, WU, FIN} state_t;

  localparam logic [3:0] LastLayer = 4'(NumLayers - 1);

  state_t            state, state_nx;
  logic [3:0]        layer, layer_nx;
  // One bit wider than the length so len + fill/drain never wraps.
  logic [cntWidth:0] cnt, cnt_nx, plen_m1;
  logic [cntWidth-1:0] len_q;
  logic              phase_end, win_nx;
  logic [1:0]        code_nx;

  assign plen_m1   = {1'b0, len_q} + (cntWidth+1)'(SysDimension - 1);
  assign phase_end = (cnt == plen_m1);
  assign win_nx    = (cnt_nx >= (cntWidth+1)'(SysDimension));

  always_comb begin
    state_nx = state;
    layer_nx = layer;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = mode ? FW : INF;
          layer_nx = 4'd0;
          cnt_nx   = '0;
        end
      end
      FIN: begin
        state_nx = IDLE;
        layer_nx = 4'd0;
        cnt_nx   = '0;
      end
      default: begin
        if (halt) begin
          state_nx = IDLE;
          layer_nx = 4'd0;
          cnt_nx   = '0;
        end else if (!phase_end) begin
          cnt_nx = cnt + 1'b1;
        end else begin
          cnt_nx = '0;
          case (state)
            INF: begin
              if (layer == LastLayer) begin
                state_nx = FIN;
                layer_nx = 4'd0;
              end else begin
                layer_nx = layer + 4'd1;
              end
            end
            FW: begin
              if (layer == LastLayer) state_nx = BW;
              else                    layer_nx = layer + 4'd1;
            end
            // Layer 0 has no backward phase; weight update restarts from the top.
            BW: begin
              if (layer == 4'd1) begin
                state_nx = WU;
                layer_nx = LastLayer;
              end else begin
                layer_nx = layer - 4'd1;
              end
            end
            WU: begin
              if (layer == 4'd0) state_nx = FIN;
              else               layer_nx = layer - 4'd1;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    code_nx = 2'd0;
    case (state_nx)
      FW:      code_nx = 2'd1;
      BW:      code_nx = 2'd2;
      WU:      code_nx = 2'd3;
      default: code_nx = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      layer              <= 4'd0;
      cnt                <= '0;
      len_q              <= '0;
      enable             <= 1'b0;
      sel1               <= 2'd0;
      sel2               <= 2'd0;
      enact              <= 1'b0;
      enactd             <= 1'b0;
      enwu               <= 1'b0;
      weightWriteEnableA <= 1'b0;
      layerIdx           <= 4'd0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      state    <= state_nx;
      layer    <= layer_nx;
      cnt      <= cnt_nx;
      if (state == IDLE && start)
        len_q <= (streamLength == '0) ? cntWidth'(1) : streamLength;
      // Outputs are registered from next-state values so they align with their state.
      enable             <= (state_nx inside {INF, FW, BW, WU});
      sel1               <= code_nx;
      sel2               <= code_nx;
      enact              <= (state_nx == INF || state_nx == FW) && win_nx;
      enactd             <= (state_nx == BW) && win_nx;
      enwu               <= (state_nx == WU) && win_nx;
      weightWriteEnableA <= enwu;
      layerIdx           <= layer_nx;
      busy               <= (state_nx != IDLE);
      done               <= (state_nx == FIN);
    end
  end

`ifdef CU_PHASE_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      perfCycles <= 32'd0;
    else if (state == IDLE && start)
      perfCycles <= 32'd0;
    else if (busy && perfCycles != 32'hFFFF_FFFF)
      perfCycles <= perfCycles + 32'd1;
  end
`endif

endmodule

// File: doc/cu_phase_ctrl.md
Name: cu_phase_ctrl

Overview:
Control-side initiator for the compute unit. It drives the enable, mux-select, activation, derivative, weight-update and weight-write controls that the compute unit only consumes. The block sequences inference, or a full training pass (forward, backward, weight update), layer by layer. Each layer phase is timed from the latched stream length plus the systolic fill/drain depth.

Parameters:
SysDimension, 16, systolic array edge; sets the fill/drain cycles added to every layer phase
NumLayers, 3, network depth (number of layers sequenced); legal range 2..15
cntWidth, 16, width of streamLength and the in-phase cycle counter

Ports:
clk  input  1  single clock
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to begin a pass; ignored while busy=1
mode  input  1  0 = inference only, 1 = training pass; sampled with start
streamLength  input  cntWidth  vectors streamed per layer; sampled with start
halt  input  1  synchronous abort
enable  output  1  compute unit global enable
sel1  output  2  weight-side mux select: 0 inf, 1 fw, 2 bw, 3 wu
sel2  output  2  activation-side mux select, same encoding as sel1
enact  output  1  relu array enable
enactd  output  1  relu-derivative array enable
enwu  output  1  weight-update array enable
weightWriteEnableA  output  1  weight buffer port A write strobe
layerIdx  output  4  current layer index
busy  output  1  pass in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0; state IDLE; counters 0.
  - Reset asserted mid-pass aborts immediately; no done pulse is generated.
- States: IDLE, INF, FW, BW, WU, FIN.
- Start:
  - In IDLE, start=1 latches mode and streamLength. A latched length of 0 is treated as 1.
  - Next state is INF (mode=0) or FW (mode=1).
  - busy=1 from the cycle after start until the FIN cycle inclusive.
- Phase length:
  - Every layer phase lasts P = len + SysDimension cycles.
  - The in-phase counter runs 0..P-1, then resets to 0 on each layer or state change.
- Layer ordering:
  - INF: layers 0..NumLayers-1, then FIN.
  - FW: layers 0..NumLayers-1, then BW.
  - BW: layers NumLayers-1 down to 1, then WU. No backward phase for layer 0.
  - WU: layers NumLayers-1 down to 0, then FIN.
- FIN: lasts one cycle, pulses done=1, then returns to IDLE.
- Outputs are registered and valid in the same cycle as the state they belong to:
  - enable=1 in INF, FW, BW and WU; 0 in IDLE and FIN.
  - sel1 = sel2 = phase code (INF 0, FW 1, BW 2, WU 3); both are 0 in IDLE and FIN.
  - enact=1 in INF and FW when the counter ≥ SysDimension (drain window, len cycles).
  - enactd=1 in BW over the same window.
  - enwu=1 in WU over the same window.
  - weightWriteEnableA = enwu delayed by exactly 1 cycle, matching the 1-cycle weight-update latency. Its final pulse may fall in the FIN cycle.
- halt:
  - When busy, halt=1 forces IDLE on the next edge.
  - All outputs drop to 0, except weightWriteEnableA, which still completes its pending 1-cycle delayed pulse.
  - No done pulse.
  - halt is ignored in IDLE.
- Simultaneous start and halt in IDLE: start wins.
- start while busy: ignored, with no effect on the latched values.
- layerIdx: holds the current layer; 0 in IDLE.

Optional Feature:
CU_PHASE_PERF_EN
- Defined: adds an output perfCycles (32-bit).
  - Cleared when a pass starts; increments every busy cycle; holds its value after done until the next start.
  - Saturates at all-ones.
  - Reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset mid-pass: assert rst=0 during FW layer 1 -> all outputs 0 within the same cycle, no done; after release, state is IDLE.
- Inference: mode=0, streamLength=4, SysDimension=16, NumLayers=3 -> busy for 3×20 + 1 = 61 cycles; enact high 4 cycles per layer at counter 16..19; sel1=sel2=0; done pulses once.
- Training: mode=1, streamLength=2 -> phase order FW0, FW1, FW2, BW2, BW1, WU2, WU1, WU0, FIN; total 8×18 + 1 = 145 busy cycles; enactd pulses 2 cycles per BW layer; sel codes 1, 2, 3 per phase.
- Write strobe timing: in a training pass, weightWriteEnableA equals enwu shifted by one cycle; total write count = 3 × 2 = 6 with streamLength=2.
- Zero length and start while busy: streamLength=0 -> phase length 17; a start pulse mid-pass changes nothing and the pass completes with a single done.
- halt: assert halt during BW layer 2, counter 5 -> enable, sel1, sel2, enactd and busy are 0 on the next cycle; no done; a new start then runs normally.
